// File: rtl/fp_alu_pkg.sv
// Shared definitions for the floating ALU: operand width, sqrt flag layout
// and the sqrt scheduler state encoding.
package fp_alu_pkg;

  localparam int FP_W    = 32;
  localparam int FLG_W   = 3;
  localparam int FLG_OVF = 0;
  localparam int FLG_UNF = 1;
  localparam int FLG_EXC = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } sq_state_e;

  // Latency counter must hold SQRT_LAT-1 and never collapse to zero width.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// after rr_ptr, wrapping modulo N_REQ.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_vld
);

  logic [ID_W:0]   sum;
  logic [ID_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_vld = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int i = 0; i < N_REQ; i++) begin
      // rr_ptr < N_REQ, so a single conditional subtract performs the modulo.
      sum = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (sum >= (ID_W+1)'(N_REQ)) begin
        sum = sum - (ID_W+1)'(N_REQ);
      end
      idx = sum[ID_W-1:0];
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = idx;
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fsqrt_rr_scheduler.sv
// Shares one multi-cycle F_Sqrt unit among N_REQ requesters: round-robin issue,
// fixed-latency EN window, result capture and a one-cycle response pulse.
module fsqrt_rr_scheduler
  import fp_alu_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int SQRT_LAT = 4,
  parameter int ID_W     = $clog2(N_REQ)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*FP_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [FP_W-1:0]       rsp_data,
  output logic [FLG_W-1:0]      rsp_flags,
  output logic                  busy,
  output logic                  sq_en,
  output logic [FP_W-1:0]       sq_a,
  input  logic [FP_W-1:0]       sq_result,
  input  logic                  sq_ovf,
  input  logic                  sq_unf,
  input  logic                  sq_exc
);

  localparam int CNT_W = cnt_width(SQRT_LAT);

  sq_state_e        state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FP_W-1:0]  sq_a_q, sq_a_d;
  logic [FP_W-1:0]  rsp_data_q, rsp_data_d;
  logic [FLG_W-1:0] rsp_flags_q, rsp_flags_d;
  logic             sq_en_q, sq_en_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_vld;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_vld (grant_vld)
  );

  // Ready is combinational, but must also read zero while reset is held.
  assign req_ready = (state_q == ST_IDLE && !RST) ? grant : '0;
  assign busy      = (state_q != ST_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_flags = rsp_flags_q;
  assign sq_en     = sq_en_q;
  assign sq_a      = sq_a_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    sq_a_d      = sq_a_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    sq_en_d     = sq_en_q;
    rsp_valid_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          owner_d = grant_id;
          sq_en_d = 1'b1;
          state_d = ST_ISSUE;
          for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              sq_a_d = req_data[i*FP_W +: FP_W];
            end
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = CNT_W'(SQRT_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d           = sq_result;
          rsp_flags_d[FLG_OVF] = sq_ovf;
          rsp_flags_d[FLG_UNF] = sq_unf;
          rsp_flags_d[FLG_EXC] = sq_exc;
          sq_en_d              = 1'b0;
          rsp_valid_d          = N_REQ'(1) << owner_q;
          state_d              = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (owner_q == ID_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      sq_a_q      <= '0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      sq_en_q     <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      sq_a_q      <= sq_a_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      sq_en_q     <= sq_en_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

endmodule

// File: tb/tb_fsqrt_rr_scheduler.sv
// Directed bench for fsqrt_rr_scheduler with a fixed-latency F_Sqrt model that
// drives garbage until EN has been high for SQRT_LAT edges.
module tb_fsqrt_rr_scheduler;

  localparam int N_REQ    = 4;
  localparam int SQRT_LAT = 4;
  localparam int ID_W     = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data  = '0;
  logic [3:0]   req_ready;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic [2:0]   rsp_flags;
  logic         busy;
  logic         sq_en;
  logic [31:0]  sq_a;
  logic [31:0]  sq_result;
  logic         sq_ovf, sq_unf, sq_exc;

  fsqrt_rr_scheduler #(
    .N_REQ    (N_REQ),
    .SQRT_LAT (SQRT_LAT),
    .ID_W     (ID_W)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_flags (rsp_flags),
    .busy      (busy),
    .sq_en     (sq_en),
    .sq_a      (sq_a),
    .sq_result (sq_result),
    .sq_ovf    (sq_ovf),
    .sq_unf    (sq_unf),
    .sq_exc    (sq_exc)
  );

  always #5 CLK = ~CLK;

  // F_Sqrt model: output is only meaningful after SQRT_LAT EN-high edges.
  int en_cnt;
  always @(posedge CLK or posedge RST) begin
    if (RST)        en_cnt <= 0;
    else if (sq_en) en_cnt <= (en_cnt < 100) ? en_cnt + 1 : en_cnt;
    else            en_cnt <= 0;
  end

  function automatic logic [31:0] sqrt_lut(input logic [31:0] a);
    case (a)
      32'h41C80000: return 32'h40A00000;
      32'h41800000: return 32'h40800000;
      32'h40800000: return 32'h40000000;
      32'h42C80000: return 32'h41200000;
      default:      return a[31] ? 32'h7FC00000 : 32'h3F800000;
    endcase
  endfunction

  logic model_ok;
  assign model_ok  = (en_cnt >= SQRT_LAT);
  assign sq_result = model_ok ? sqrt_lut(sq_a) : 32'hDEADBEEF;
  assign sq_exc    = model_ok ? (sq_a[31] && (sq_a[30:0] != 31'd0)) : 1'b1;
  assign sq_ovf    = !model_ok;
  assign sq_unf    = !model_ok;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [3:0]  sticky = '0;
  logic [3:0]  exp_oh  [8];
  logic [31:0] exp_dat [8];
  logic [2:0]  exp_flg [8];

  task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: requesters drop valid after a handshake unless marked sticky.
  task automatic step();
    logic [3:0] hs;
    #1;
    hs = req_valid & req_ready;
    @(posedge CLK);
    #1;
    req_valid = req_valid & ~(hs & ~sticky);
    @(negedge CLK);
    cyc++;
  endtask

  task automatic collect(input int n, input string tag);
    int k, budget, last;
    k = 0; budget = 0; last = -1;
    while (k < n && budget < 200) begin
      step();
      budget++;
      if (rsp_valid != 4'b0) begin
        chk_vec({tag, "_oh"},   {28'd0, rsp_valid}, {28'd0, exp_oh[k]});
        chk_vec({tag, "_data"}, rsp_data, exp_dat[k]);
        chk_vec({tag, "_flag"}, {29'd0, rsp_flags}, {29'd0, exp_flg[k]});
        if (last >= 0) chk_vec({tag, "_gap"}, cyc - last, SQRT_LAT + 3);
        last = cyc;
        k++;
      end
    end
    if (k < n) chk_vec({tag, "_timeout"}, k, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_hi, rsp_k, pulses, stray;

    // Reset state
    req_valid = 4'b0001;
    req_data[31:0] = 32'h41C80000;
    @(negedge CLK); @(negedge CLK);
    chk_vec("rst_ctrl", {25'd0, sq_en, busy, rsp_valid, req_ready, 1'b0}, 32'd0);
    chk_vec("rst_sqa", sq_a, 32'd0);
    chk_vec("rst_rsp", {29'd0, rsp_flags} | rsp_data, 32'd0);
    req_valid = 4'b0000;
    RST = 1'b0;
    step();
    chk_vec("idle_ready", {28'd0, req_ready}, 32'd0);
    chk_vec("idle_busy", {31'd0, busy}, 32'd0);

    // Single request: 25.0 -> 5.0 with fixed latency
    req_data[31:0] = 32'h41C80000;
    req_valid = 4'b0001;
    #1;
    chk_vec("t2_ready", {28'd0, req_ready}, 32'h1);
    en_hi = 0; rsp_k = -1; pulses = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (sq_en) en_hi++;
      if (k == 1) chk_vec("t2_sqa", sq_a, 32'h41C80000);
      if (k == 1) chk_vec("t2_busy_ready", {30'd0, busy, |req_ready}, 32'h2);
      if (rsp_valid != 4'b0) begin
        pulses++;
        if (rsp_k < 0) begin
          rsp_k = k;
          chk_vec("t2_oh", {28'd0, rsp_valid}, 32'h1);
          chk_vec("t2_data", rsp_data, 32'h40A00000);
          chk_vec("t2_flag", {29'd0, rsp_flags}, 32'd0);
        end
      end
    end
    chk_vec("t2_lat", rsp_k, SQRT_LAT + 2);
    chk_vec("t2_en_cycles", en_hi, SQRT_LAT + 1);
    chk_vec("t2_pulses", pulses, 1);
    chk_vec("t2_hold", rsp_data, 32'h40A00000);

    // Reset in the middle of WAIT aborts the op
    req_data[63:32] = 32'h41800000;
    req_valid = 4'b0010;
    step(); step(); step();
    chk_vec("t1_en_pre", {31'd0, sq_en}, 32'h1);
    req_valid = 4'b0001;
    #2;
    RST = 1'b1;
    #1;
    chk_vec("t1_ctrl", {25'd0, sq_en, busy, rsp_valid, req_ready, 1'b0}, 32'd0);
    chk_vec("t1_sqa", sq_a, 32'd0);
    chk_vec("t1_rspdata", rsp_data, 32'd0);
    chk_vec("t1_flags", {29'd0, rsp_flags}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    req_valid = 4'b0000;
    RST = 1'b0;
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (rsp_valid != 4'b0 || busy || req_ready != 4'b0) stray++;
    end
    chk_vec("t1_after", stray, 0);

    // Contention from reset: grants 0,1,2,3
    req_data = {32'h42C80000, 32'h41C80000, 32'h40800000, 32'h41800000};
    req_valid = 4'b1111;
    RST = 1'b1;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    exp_oh[0] = 4'b0001; exp_dat[0] = 32'h40800000; exp_flg[0] = 3'b000;
    exp_oh[1] = 4'b0010; exp_dat[1] = 32'h40000000; exp_flg[1] = 3'b000;
    exp_oh[2] = 4'b0100; exp_dat[2] = 32'h40A00000; exp_flg[2] = 3'b000;
    exp_oh[3] = 4'b1000; exp_dat[3] = 32'h41200000; exp_flg[3] = 3'b000;
    collect(4, "t3");

    // Fairness and wrap: 0 and 3 held valid alternate
    req_data[31:0]   = 32'h41800000;
    req_data[127:96] = 32'h40800000;
    sticky = 4'b1001;
    req_valid = 4'b1001;
    exp_oh[0] = 4'b0001; exp_dat[0] = 32'h40800000; exp_flg[0] = 3'b000;
    exp_oh[1] = 4'b1000; exp_dat[1] = 32'h40000000; exp_flg[1] = 3'b000;
    exp_oh[2] = 4'b0001; exp_dat[2] = 32'h40800000; exp_flg[2] = 3'b000;
    exp_oh[3] = 4'b1000; exp_dat[3] = 32'h40000000; exp_flg[3] = 3'b000;
    collect(4, "t4");
    req_valid = 4'b0000;
    sticky = 4'b0000;

    // Exception path, then a new grant one cycle after DONE
    req_data[63:32] = 32'hC1800000;
    req_valid = 4'b0010;
    exp_oh[0] = 4'b0010; exp_dat[0] = 32'h7FC00000; exp_flg[0] = 3'b100;
    collect(1, "t5");
    req_data[31:0] = 32'h40800000;
    req_valid = 4'b0001;
    #1;
    chk_vec("t5_ready_done", {28'd0, req_ready}, 32'd0);
    step();
    chk_vec("t5_ready_next", {28'd0, req_ready}, 32'h1);
    exp_oh[0] = 4'b0001; exp_dat[0] = 32'h40000000; exp_flg[0] = 3'b000;
    collect(1, "t5b");

    // Valid dropped mid-op: the latched operand still completes once
    req_data[95:64] = 32'h41C80000;
    sticky = 4'b0100;
    req_valid = 4'b0100;
    step(); step(); step();
    chk_vec("t6_en_wait", {31'd0, sq_en}, 32'h1);
    req_valid = 4'b0000;
    sticky = 4'b0000;
    exp_oh[0] = 4'b0100; exp_dat[0] = 32'h40A00000; exp_flg[0] = 3'b000;
    collect(1, "t6");
    stray = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rsp_valid != 4'b0 || busy) stray++;
    end
    chk_vec("t6_no_regrant", stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
